mem_access_stage: RTL

Memory-access stage of the pipelined core, directly downstream of the EX/MEM pipeline latch and upstream of write-back. It issues the load or store described by the EX/MEM outputs to the data cache and holds the request until `dhit_i`. It stalls the upstream pipeline while waiting and registers the write-back result (MEM/WB latch). It also keeps a sticky halt state and a load-linked reservation for LL/SC.

---
 rtl/mem_access_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing cache requests, stalling on misses, latching MEM/WB, sticky halt, LL/SC link.
// Build with MEM_LLSC_EN defined to get the load-linked reservation; otherwise SC always succeeds.
module mem_access_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] aluout_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] extout_i,
  input  logic              dren_i,
  input  logic              dwen_i,
  input  logic              regw_i,
  input  logic              lui_i,
  input  logic              jal_i,
  input  logic              halt_i,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic [REG_W-1:0]  wsel_i,
  input  logic              flush_i,
  output logic              dmemREN_o,
  output logic              dmemWEN_o,
  output logic [WORD_W-1:0] dmemaddr_o,
  output logic [WORD_W-1:0] dmemstore_o,
  input  logic              dhit_i,
  input  logic [WORD_W-1:0] dmemload_i,
  input  logic              ccinv_i,
  input  logic [WORD_W-1:0] ccaddr_i,
  output logic              stall_o,
  output logic [WORD_W-1:0] wdat_o,
  output logic [REG_W-1:0]  wsel_o,
  output logic              regw_o,
  output logic              halt_o,
  output logic [15:0]       waitcnt_o
);
  typedef enum logic [1:0] {RUN, WAIT, HALTED} state_t;
  state_t state_q, state_d;
  logic [WORD_W-1:0] wdat_q, wb;
  logic [REG_W-1:0]  wsel_q;
  logic              regw_q;
  logic [15:0]       waitcnt_q;
  logic              sc_ok, memop, halt_go, bubble;
`ifdef MEM_LLSC_EN
  logic              lvalid_q;
  logic [WORD_W-1:0] laddr_q;
  logic              snoop;
  assign snoop = ccinv_i & (ccaddr_i == laddr_q);
  assign sc_ok = lvalid_q & (laddr_q == aluout_i) & ~snoop;
  // An LL hit takes priority over a simultaneous invalidate of the old link.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lvalid_q <= 1'b0;
      laddr_q  <= '0;
    end else if (memop & dren_i & ll_i & dhit_i) begin
      lvalid_q <= 1'b1;
      laddr_q  <= aluout_i;
    end else if (snoop | (memop & dwen_i & dhit_i & (aluout_i == laddr_q))) begin
      lvalid_q <= 1'b0;
    end
  end
`else
  logic unused_llsc;
  assign unused_llsc = ^{ll_i, ccinv_i, ccaddr_i};
  assign sc_ok = 1'b1;
`endif
  always_comb begin
    memop       = (dren_i | (dwen_i & ~(sc_i & ~sc_ok))) & ~flush_i & (state_q != HALTED);
    dmemREN_o   = memop & dren_i;
    dmemWEN_o   = memop & dwen_i & ~dren_i;
    dmemaddr_o  = aluout_i;
    dmemstore_o = rdat2_i;
    stall_o     = memop & ~dhit_i;
    halt_go     = halt_i & ~flush_i & ~stall_o;
    bubble      = stall_o | flush_i | (state_q == HALTED);
    wb          = jal_i ? npc_i : lui_i ? extout_i : dren_i ? dmemload_i :
                  sc_i ? WORD_W'(sc_ok) : aluout_i;
    state_d     = (state_q == HALTED || halt_go) ? HALTED : stall_o ? WAIT : RUN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      wdat_q    <= '0;
      wsel_q    <= '0;
      regw_q    <= 1'b0;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wdat_q    <= bubble ? '0 : wb;
      wsel_q    <= bubble ? '0 : wsel_i;
      regw_q    <= ~bubble & ~halt_go & regw_i;
      waitcnt_q <= waitcnt_q + 16'(stall_o & ~&waitcnt_q);
    end
  end
  assign wdat_o    = wdat_q;
  assign wsel_o    = wsel_q;
  assign regw_o    = regw_q;
  assign halt_o    = state_q == HALTED;
  assign waitcnt_o = waitcnt_q;
endmodule
